// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter.
// No logic. The master modport is the arbiter; the slave modport drives requesters and the FIFO.
// Backpressure: fifo_full is the only back-pressure input; req_ready is the per-requester accept.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [IDW+DATA_WIDTH-1:0]     fifo_din;
  logic [IDW-1:0]                grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: N requesters into one FIFO write port, tagging each beat with its source id.
// Latency 1: an accepted beat is presented on fifo_din in the following cycle.
// Backpressure: a one-register output stage holds while fifo_full; req_ready is low unless the stage can load.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_wr_arbiter_if.master    bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]          lock_id_q, lock_id_d;
  logic [IDW-1:0]          grant_last_q, grant_last_d;
  logic [3:0]              burst_cnt_q, burst_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [IDW-1:0]          out_id_q, out_id_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];
  logic                    srch_found;
  logic [IDW-1:0]          srch_idx;
  logic [IDW-1:0]          sel_id;
  logic [IDW-1:0]          grant_int;
  logic [NUM_REQ-1:0]      ready_int;
  logic [3:0]              burst_inc;
  logic                    accept;
  logic                    wr_en;
  logic                    can_load;

  // Next round-robin pointer with explicit wrap for non-power-of-two NUM_REQ.
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + IDW'(1);
  endfunction

  // Split the flat payload bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_word[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    srch_found = 1'b0;
    srch_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!srch_found && bus.req_valid[IDW'(idx)]) begin
        srch_found = 1'b1;
        srch_idx   = IDW'(idx);
      end
    end
  end

  assign wr_en    = out_valid_q && !bus.fifo_full;
  assign can_load = !out_valid_q || wr_en;

  // Grant FSM and output-stage next state.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_id_d    = lock_id_q;
    burst_cnt_d  = burst_cnt_q;
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_data_d   = out_data_q;
    accept       = 1'b0;
    ready_int    = '0;
    sel_id       = srch_idx;
    burst_inc    = burst_cnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        sel_id = srch_idx;
        if (srch_found && can_load) begin
          accept = 1'b1;
          if (MAX_BURST == 1) begin
            rr_ptr_d = next_ptr(srch_idx);
          end else begin
            state_d     = BURST;
            lock_id_d   = srch_idx;
            burst_cnt_d = 4'd1;
          end
        end
      end
      BURST: begin
        sel_id = lock_id_q;
        if (!bus.req_valid[lock_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr(lock_id_q);
        end else if (can_load) begin
          accept      = 1'b1;
          burst_cnt_d = burst_inc;
          if (burst_inc == 4'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr(lock_id_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      ready_int[sel_id] = 1'b1;
      out_valid_d       = 1'b1;
      out_id_d          = sel_id;
      out_data_d        = req_word[sel_id];
    end else if (wr_en) begin
      out_valid_d = 1'b0;
    end
  end

  // Grant id shows the lock in BURST, the search result in IDLE, else the last shown value.
  always_comb begin
    if (state_q == BURST)  grant_int = lock_id_q;
    else if (srch_found)   grant_int = srch_idx;
    else                   grant_int = grant_last_q;
    grant_last_d = grant_int;
  end

  // All state; reset discards any beat held in the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      lock_id_q    <= '0;
      grant_last_q <= '0;
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_id_q    <= lock_id_d;
      grant_last_q <= grant_last_d;
      burst_cnt_q  <= burst_cnt_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_data_q   <= out_data_d;
    end
  end

  // Outputs are forced quiet while reset is held, whatever the requesters are doing.
  assign bus.req_ready  = rst_n ? ready_int : '0;
  assign bus.grant_id   = rst_n ? grant_int : '0;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_din   = {out_id_q, out_data_q};
  assign bus.busy       = (state_q == BURST) || out_valid_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: two instances (4x32 burst 4, and 3x8 burst 1).
module tb_fifo_wr_arbiter;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fifo_wr_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4)) ia ();
  fifo_wr_arbiter_if #(.DATA_WIDTH(8),  .NUM_REQ(3)) ib ();

  fifo_wr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.master));
  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ia.req_valid = '0;
    ib.req_valid = '0;
    ia.fifo_full = 1'b0;
    ib.fifo_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [33:0] sbq[$];
  int          wt[4];
  int          max_wait;

  // One scoreboard cycle on instance a: retire writes, record accepts, track waiting.
  task automatic sb_cycle();
    logic [33:0] e;
    logic        any_acc;
    #1;
    if (ia.fifo_wr_en) begin
      if (sbq.size() == 0) chk("sb_spurious_wr", 64'(ia.fifo_wr_en), 64'd0);
      else begin
        e = sbq.pop_front();
        chk("sb_order", 64'(ia.fifo_din), 64'(e));
      end
    end
    chk("onehot_ready", 64'($countones(ia.req_ready) <= 1), 64'd1);
    any_acc = |(ia.req_valid & ia.req_ready);
    for (int i = 0; i < 4; i++) begin
      if (ia.req_valid[i] && ia.req_ready[i])
        sbq.push_back({2'(i), ia.req_data[i*32 +: 32]});
      if (!ia.req_valid[i] || ia.req_ready[i]) wt[i] = 0;
      else if (any_acc) wt[i]++;
      if (wt[i] > max_wait) max_wait = wt[i];
    end
    tick();
  endtask

  logic [3:0] v31 [8] = '{4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1001};
  logic [3:0] r31 [8] = '{4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
  logic [1:0] g31 [8] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
  logic       w31 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       b31 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int          g;
    int          pg;
    logic [33:0] ea;
    logic [9:0]  eb;
    vectors     = 0;
    miscompares = 0;
    max_wait    = 0;
    rst_n        = 1'b0;
    ia.req_valid = '0;
    ia.req_data  = '0;
    ia.fifo_full = 1'b0;
    ib.req_valid = '0;
    ib.req_data  = '0;
    ib.fifo_full = 1'b0;

    // Reset: outputs quiet even with every requester valid.
    ia.req_valid = 4'b1111;
    ib.req_valid = 3'b111;
    #2;
    chk("rst_wr_en", 64'(ia.fifo_wr_en), 64'd0);
    chk("rst_ready", 64'(ia.req_ready), 64'd0);
    chk("rst_grant", 64'(ia.grant_id), 64'd0);
    chk("rst_busy", 64'(ia.busy), 64'd0);
    chk("rst_ready_b", 64'(ib.req_ready), 64'd0);
    tick();
    tick();
    ib.req_valid = '0;
    rst_n = 1'b1;

    // All four valid: 4 beats each from 0,1,2,3 then 0 again, back to back.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) ia.req_data[i*32 +: 32] = 32'(32'h100 * i + k);
      #1;
      g = (k / 4) % 4;
      chk("rr_grant", 64'(ia.grant_id), 64'(g));
      chk("rr_ready", 64'(ia.req_ready), 64'(4'b0001 << g));
      if (k > 0) begin
        pg = ((k - 1) / 4) % 4;
        ea = {2'(pg), 32'(32'h100 * pg + k - 1)};
        chk("rr_wr_en", 64'(ia.fifo_wr_en), 64'd1);
        chk("rr_din", 64'(ia.fifo_din), 64'(ea));
      end else begin
        chk("rr_wr_en0", 64'(ia.fifo_wr_en), 64'd0);
      end
      tick();
    end

    // Requester 2 drops after 2 beats; one idle cycle, then 3; pointer wraps to 0.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      ia.req_valid = v31[k];
      #1;
      chk("drop_ready", 64'(ia.req_ready), 64'(r31[k]));
      chk("drop_grant", 64'(ia.grant_id), 64'(g31[k]));
      chk("drop_wr_en", 64'(ia.fifo_wr_en), 64'(w31[k]));
      chk("drop_busy", 64'(ia.busy), 64'(b31[k]));
      tick();
    end

    // FIFO full for 5 cycles with a beat held.
    do_reset();
    ia.req_valid = 4'b0001;
    ia.req_data[31:0] = 32'hC000_0000;
    #1;
    chk("stall_ready0", 64'(ia.req_ready), 64'd1);
    chk("stall_wr0", 64'(ia.fifo_wr_en), 64'd0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      ia.req_data[31:0] = 32'hC000_0000 + 32'(k);
      ia.fifo_full = 1'b1;
      #1;
      chk("stall_wr_en", 64'(ia.fifo_wr_en), 64'd0);
      chk("stall_din", 64'(ia.fifo_din), {30'd0, 2'd0, 32'hC000_0000});
      chk("stall_ready", 64'(ia.req_ready), 64'd0);
      tick();
    end
    ia.fifo_full = 1'b0;
    ia.req_data[31:0] = 32'hC000_0006;
    #1;
    chk("release_wr_en", 64'(ia.fifo_wr_en), 64'd1);
    chk("release_din", 64'(ia.fifo_din), {30'd0, 2'd0, 32'hC000_0000});
    chk("release_ready", 64'(ia.req_ready), 64'd1);
    tick();
    ia.req_data[31:0] = 32'hC000_0007;
    #1;
    chk("release_wr2", 64'(ia.fifo_wr_en), 64'd1);
    chk("release_din2", 64'(ia.fifo_din), {30'd0, 2'd0, 32'hC000_0006});
    tick();

    // Reset asserted mid-burst with a beat held.
    do_reset();
    ia.req_valid = 4'b1111;
    tick();
    tick();
    chk("midrst_pre_busy", 64'(ia.busy), 64'd1);
    chk("midrst_pre_wr", 64'(ia.fifo_wr_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 64'(ia.fifo_wr_en), 64'd0);
    chk("midrst_busy", 64'(ia.busy), 64'd0);
    chk("midrst_ready", 64'(ia.req_ready), 64'd0);
    tick();
    ia.req_valid = 4'b1110;
    rst_n = 1'b1;
    #1;
    chk("postrst_grant", 64'(ia.grant_id), 64'd1);
    chk("postrst_ready", 64'(ia.req_ready), 64'b0010);
    chk("postrst_wr_en", 64'(ia.fifo_wr_en), 64'd0);
    tick();

    // Three requesters, burst of 1, only requester 2 valid.
    do_reset();
    ib.req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      ib.req_data[23:16] = 8'(8'h20 + k);
      #1;
      chk("n3_ready", 64'(ib.req_ready), 64'b100);
      chk("n3_grant", 64'(ib.grant_id), 64'd2);
      if (k > 0) begin
        eb = {2'd2, 8'(8'h20 + k - 1)};
        chk("n3_wr_en", 64'(ib.fifo_wr_en), 64'd1);
        chk("n3_din", 64'(ib.fifo_din), 64'(eb));
      end
      tick();
    end
    ib.req_valid = 3'b101;
    #1;
    chk("n3_wrap_grant", 64'(ib.grant_id), 64'd0);
    chk("n3_wrap_ready", 64'(ib.req_ready), 64'b001);
    tick();
    #1;
    chk("n3_next_grant", 64'(ib.grant_id), 64'd2);
    tick();
    #1;
    chk("n3_wrap2_grant", 64'(ib.grant_id), 64'd0);
    tick();
    ib.req_valid = '0;

    // Random valid/full traffic against a scoreboard.
    do_reset();
    sbq.delete();
    for (int i = 0; i < 4; i++) wt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        ia.req_valid[i] = ($urandom_range(0, 3) != 0);
        ia.req_data[i*32 +: 32] = $urandom;
      end
      ia.fifo_full = ($urandom_range(0, 3) == 0);
      sb_cycle();
    end
    ia.req_valid = '0;
    ia.fifo_full = 1'b0;
    for (int c = 0; c < 4; c++) sb_cycle();
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    chk("sb_fair", 64'(max_wait <= 12), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
